// File: rtl/led_palette_override_arbiter.sv
// Round-robin override arbiter between the palette pulser and the LED PWM driver.
// Optional requester-0 preemption is enabled by defining LED_ARB_PREEMPT_EN.
module led_palette_override_arbiter #(
    parameter int parm_color_led_count  = 4,
    parameter int parm_req_count        = 4,
    parameter int parm_FCLK             = 40_000_000,
    parameter int parm_ticks_per_second = 128,
    localparam int C  = parm_color_led_count,
    localparam int R  = parm_req_count,
    localparam int CI = (C > 1) ? $clog2(C) : 1,
    localparam int RI = (R > 1) ? $clog2(R) : 1
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic [8*C-1:0]  i_base_red_value,
    input  logic [8*C-1:0]  i_base_green_value,
    input  logic [8*C-1:0]  i_base_blue_value,
    input  logic [R-1:0]    i_req_valid,
    input  logic [CI*R-1:0] i_req_led_index,
    input  logic [24*R-1:0] i_req_rgb,
    input  logic [8*R-1:0]  i_req_hold,
    output logic [R-1:0]    o_req_ready,
    output logic            o_busy,
    output logic [RI-1:0]   o_grant_id,
    output logic [8*C-1:0]  o_color_led_red_value,
    output logic [8*C-1:0]  o_color_led_green_value,
    output logic [8*C-1:0]  o_color_led_blue_value
);

    localparam int D  = parm_FCLK / parm_ticks_per_second;
    localparam int TW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic [7:0]    hold_cnt;
    logic [RI-1:0] rr_ptr;
    logic [RI-1:0] grant;
    logic [CI-1:0] idx;
    logic [23:0]   rgb;

    logic          found;
    logic [RI-1:0] win;
    int            j;
    logic          preempt;
    logic          accept;
    logic [RI-1:0] acc_id;

    logic [CI-1:0] req_idx  [R];
    logic [23:0]   req_rgb  [R];
    logic [7:0]    req_hold [R];

    for (genvar r = 0; r < R; r++) begin : g_unpack
        assign req_idx[r]  = i_req_led_index[r*CI +: CI];
        assign req_rgb[r]  = i_req_rgb[r*24 +: 24];
        assign req_hold[r] = i_req_hold[r*8 +: 8];
    end

    assign tick = (tcnt == TW'(D - 1));

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int i = 1; i <= R; i++) begin
            j = (int'(rr_ptr) + i) % R;
            if (!found && i_req_valid[RI'(j)]) begin
                found = 1'b1;
                win   = RI'(j);
            end
        end
    end

`ifdef LED_ARB_PREEMPT_EN
    assign preempt = (state != IDLE) && (grant != '0) && i_req_valid[0];
`else
    assign preempt = 1'b0;
`endif

    assign accept = ((state == IDLE) && found) || preempt;
    assign acc_id = preempt ? '0 : win;

    always_comb begin
        o_req_ready = '0;
        if ((state == IDLE) && found)
            o_req_ready[win] = 1'b1;
        if (preempt)
            o_req_ready[0] = 1'b1;
    end

    assign o_busy     = (state != IDLE);
    assign o_grant_id = grant;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state    <= IDLE;
            tcnt     <= '0;
            hold_cnt <= '0;
            rr_ptr   <= RI'(R - 1);
            grant    <= '0;
            idx      <= '0;
            rgb      <= '0;
        end else begin
            // Restarting the divider on accept keeps the hold phase-exact.
            if (accept || tick)
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);
            if (accept) begin
                state    <= HOLD;
                idx      <= req_idx[acc_id];
                rgb      <= req_rgb[acc_id];
                hold_cnt <= (req_hold[acc_id] == 8'd0) ? 8'd1 : req_hold[acc_id];
                rr_ptr   <= acc_id;
                grant    <= acc_id;
            end else if (tick) begin
                case (state)
                    HOLD: begin
                        if (hold_cnt == 8'd1)
                            state <= GAP;
                        else
                            hold_cnt <= hold_cnt - 8'd1;
                    end
                    GAP:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_color_led_red_value   <= '0;
            o_color_led_green_value <= '0;
            o_color_led_blue_value  <= '0;
        end else begin
            o_color_led_red_value   <= i_base_red_value;
            o_color_led_green_value <= i_base_green_value;
            o_color_led_blue_value  <= i_base_blue_value;
            // Out-of-range indices match no lane, so they pass through untouched.
            if (state == HOLD) begin
                for (int n = 0; n < C; n++) begin
                    if (idx == CI'(n)) begin
                        o_color_led_red_value[8*n +: 8]   <= rgb[23:16];
                        o_color_led_green_value[8*n +: 8] <= rgb[15:8];
                        o_color_led_blue_value[8*n +: 8]  <= rgb[7:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_palette_override_arbiter.sv
// Directed bench for led_palette_override_arbiter (D=10, five LEDs, four requesters).
module tb_led_palette_override_arbiter;

    localparam int C = 5;
    localparam int R = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [39:0]   bred, bgrn, bblu;
    logic [3:0]    valid;
    logic [11:0]   lidx;
    logic [95:0]   rgb;
    logic [31:0]   hold;
    logic [3:0]    ready;
    logic          busy;
    logic [1:0]    grant;
    logic [39:0]   ored, ogrn, oblu;
    logic [119:0]  pal;

    int checks = 0;
    int errors = 0;

    localparam logic [119:0] BASE = {40'hA4A3A2A1A0, 40'hB4B3B2B1B0, 40'hC4C3C2C1C0};
    localparam logic [119:0] AA   = {15{8'hAA}};
    localparam logic [119:0] OV1  = {40'hA4A311A1A0, 40'hB4B322B1B0, 40'hC4C333C1C0};
    localparam logic [119:0] OVR3 = {40'hA4A3A2A144, 40'hB4B3B2B155, 40'hC4C3C2C166};
    localparam logic [119:0] OVC0 = {40'hA4A3A201A0, 40'hB4B3B202B0, 40'hC4C3C203C0};
    localparam logic [119:0] OVC2 = {40'hA40AA2A1A0, 40'hB40BB2B1B0, 40'hC40CC2C1C0};
    localparam logic [119:0] OVP3 = {40'h77A3A2A1A0, 40'h88B3B2B1B0, 40'h99C3C2C1C0};
    localparam logic [119:0] OVP0 = {40'hA4A3A2A112, 40'hB4B3B2B134, 40'hC4C3C2C156};

    assign pal = {ored, ogrn, oblu};

    led_palette_override_arbiter #(
        .parm_color_led_count (C),
        .parm_req_count       (R),
        .parm_FCLK            (1000),
        .parm_ticks_per_second(100)
    ) dut (
        .i_clk                  (clk),
        .i_arst_n               (rst_n),
        .i_base_red_value       (bred),
        .i_base_green_value     (bgrn),
        .i_base_blue_value      (bblu),
        .i_req_valid            (valid),
        .i_req_led_index        (lidx),
        .i_req_rgb              (rgb),
        .i_req_hold             (hold),
        .o_req_ready            (ready),
        .o_busy                 (busy),
        .o_grant_id             (grant),
        .o_color_led_red_value  (ored),
        .o_color_led_green_value(ogrn),
        .o_color_led_blue_value (oblu)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [2:0] li, input logic [23:0] c,
                           input logic [7:0] h);
        lidx[r*3 +: 3] = li;
        rgb[r*24 +: 24] = c;
        hold[r*8 +: 8]  = h;
    endtask

    initial begin
        rst_n = 1'b0;
        bred  = {5{8'hAA}};
        bgrn  = {5{8'hAA}};
        bblu  = {5{8'hAA}};
        valid = '0;
        lidx  = '0;
        rgb   = '0;
        hold  = '0;

        // reset state
        step();
        step();
        chk("rst_pal", pal, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 4'b0000);
        chk("rst_grant", grant, 2'd0);
        rst_n = 1'b1;
        chk("rel_pre", pal, '0);
        step();
        chk("rel_pal", pal, AA);

        bred = BASE[119:80];
        bgrn = BASE[79:40];
        bblu = BASE[39:0];
        step();
        chk("pass", pal, BASE);

        // single request, hold 3 ticks
        set_req(1, 3'd2, 24'h112233, 8'd3);
        valid = 4'b0010;
        #1;
        chk("rdy1", ready, 4'b0010);
        step();
        valid = '0;
        #1;
        chk("rdy1_off", ready, 4'b0000);
        chk("busy1_acc", busy, 1'b1);
        chk("grant1", grant, 2'd1);
        for (int k = 1; k <= 41; k++) begin
            step();
            chk($sformatf("ovr1_%0d", k), pal, (k <= 30) ? OV1 : BASE);
            chk($sformatf("busy1_%0d", k), busy, (k <= 39));
        end

        // async reset in the middle of a hold
        set_req(3, 3'd0, 24'h445566, 8'd2);
        valid = 4'b1000;
        #1;
        chk("rdy3", ready, 4'b1000);
        step();
        valid = '0;
        for (int k = 1; k <= 5; k++) step();
        chk("ovr3", pal, OVR3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pal", pal, '0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_grant", grant, 2'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_rel", pal, BASE);

        // contention: req0 and req2 together
        set_req(0, 3'd1, 24'h010203, 8'd1);
        set_req(2, 3'd3, 24'h0A0B0C, 8'd0);
        valid = 4'b0101;
        #1;
        chk("c_rdy0", ready, 4'b0001);
        step();
        valid = 4'b0100;
        #1;
        chk("c_grant0", grant, 2'd0);
        for (int k = 1; k <= 19; k++) begin
            step();
            if (k == 10) chk("c_ovr0_last", pal, OVC0);
            if (k == 11) chk("c_ovr0_end", pal, BASE);
        end
        chk("c_wait_busy", busy, 1'b1);
        chk("c_wait_rdy", ready, 4'b0000);
        step();
        valid = 4'b0101;
        #1;
        chk("c_rdy2", ready, 4'b0100);
        step();
        valid = 4'b0001;
        #1;
        chk("c_grant2", grant, 2'd2);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1)  chk("c_ovr2_first", pal, OVC2);
            if (k == 10) chk("c_ovr2_last", pal, OVC2);
            if (k == 11) chk("c_ovr2_end", pal, BASE);
            if (k == 19) chk("c_busy2", busy, 1'b1);
        end
        chk("c_idle2", busy, 1'b0);
        chk("c_rdy0b", ready, 4'b0001);
        step();
        valid = '0;
        #1;
        chk("c_grant0b", grant, 2'd0);
        for (int k = 1; k <= 20; k++) step();
        chk("c_idle0b", busy, 1'b0);

        // out-of-range LED index
        set_req(1, 3'd5, 24'hFFFFFF, 8'd1);
        valid = 4'b0010;
        #1;
        chk("x_rdy", ready, 4'b0010);
        step();
        valid = '0;
        #1;
        chk("x_grant", grant, 2'd1);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 5)  chk("x_pal", pal, BASE);
            if (k == 19) chk("x_busy", busy, 1'b1);
        end
        chk("x_idle", busy, 1'b0);

        // requester 0 arriving during another grant's hold
        set_req(3, 3'd4, 24'h778899, 8'd4);
        valid = 4'b1000;
        #1;
        chk("p_rdy3", ready, 4'b1000);
        step();
        valid = '0;
        for (int k = 1; k <= 5; k++) step();
        chk("p_ovr3", pal, OVP3);
        set_req(0, 3'd0, 24'h123456, 8'd2);
        valid = 4'b0001;
        #1;
`ifdef LED_ARB_PREEMPT_EN
        chk("p_rdy0", ready, 4'b0001);
        step();
        valid = '0;
        #1;
        chk("p_grant0", grant, 2'd0);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1)  chk("p_ovr0_first", pal, OVP0);
            if (k == 20) chk("p_ovr0_last", pal, OVP0);
            if (k == 21) chk("p_ovr0_end", pal, BASE);
            if (k == 39) chk("p_busy", busy, 1'b1);
        end
        chk("p_idle", busy, 1'b0);
`else
        chk("p_rdy0_wait", ready, 4'b0000);
        step();
        chk("p_grant3", grant, 2'd3);
        step();
        chk("p_ovr3_kept", pal, OVP3);
        valid = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
